ex_alu_unit: RTL and testbench

- Execute-stage integer unit for RV32I. Computes three registered results from decode-stage operands:
  - I-type ALU (OP-IMM),
  - R-type ALU (OP),
  - AUIPC.
- Sits between instruction_decode/registers and the writeback rd_mux.
- One result register per path; writeback selects by its own one-hot opcode.

---
 rtl/ex_alu_pkg.sv | 56 +++++
 rtl/ex_alu_core.sv | 60 ++++++
 rtl/ex_alu_unit.sv | 167 ++++++++++++++++
 tb/tb_ex_alu_unit.sv | 354 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ex_alu_pkg.sv
// Shared encodings for the execute-stage integer unit: funct3/funct7 values,
// the ALU operation enum and the funct3-to-operation map for base encodings.
// Purely declarative; no logic, no latency, no flow control.
package ex_alu_pkg;

    localparam int XLEN = 32;

    // funct3 field values (OP and OP-IMM share them)
    localparam logic [2:0] F3_ADD  = 3'b000;
    localparam logic [2:0] F3_SLL  = 3'b001;
    localparam logic [2:0] F3_SLT  = 3'b010;
    localparam logic [2:0] F3_SLTU = 3'b011;
    localparam logic [2:0] F3_XOR  = 3'b100;
    localparam logic [2:0] F3_SR   = 3'b101;
    localparam logic [2:0] F3_OR   = 3'b110;
    localparam logic [2:0] F3_AND  = 3'b111;

    // funct7 field values
    localparam logic [6:0] F7_BASE   = 7'b0000000;
    localparam logic [6:0] F7_ALT    = 7'b0100000;
    localparam logic [6:0] F7_MULDIV = 7'b0000001;

    typedef enum logic [3:0] {
        ALU_ADD,
        ALU_SUB,
        ALU_SLL,
        ALU_SLT,
        ALU_SLTU,
        ALU_XOR,
        ALU_SRL,
        ALU_SRA,
        ALU_OR,
        ALU_AND,
        ALU_MUL,
        ALU_MULH,
        ALU_MULHSU,
        ALU_MULHU
    } alu_op_e;

    // Operation selected by funct3 when funct7 (or imm[11:5]) is all zero.
    function automatic alu_op_e base_op(input logic [2:0] f3);
        alu_op_e op;
        case (f3)
            F3_ADD:  op = ALU_ADD;
            F3_SLL:  op = ALU_SLL;
            F3_SLT:  op = ALU_SLT;
            F3_SLTU: op = ALU_SLTU;
            F3_XOR:  op = ALU_XOR;
            F3_SR:   op = ALU_SRL;
            F3_OR:   op = ALU_OR;
            default: op = ALU_AND;
        endcase
        return op;
    endfunction

endpackage

// File: rtl/ex_alu_core.sv
// Combinational 32-bit integer ALU shared by the OP and OP-IMM paths.
// Latency: zero (pure combinational); the caller registers the result.
// Backpressure: none; output follows inputs. Multiplies only with EX_ALU_MUL_EN.
module ex_alu_core
    import ex_alu_pkg::*;
(
    input  alu_op_e     op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [31:0] result
);

    logic [4:0] shamt;
    assign shamt = b[4:0];

`ifdef EX_ALU_MUL_EN
    logic [63:0] mul_a;
    logic [63:0] mul_b;
    logic [63:0] mul_p;

    // One 64x64 multiplier; signedness is chosen by how each operand is extended,
    // the low 64 bits of the product are then correct for every variant.
    always_comb begin
        mul_a = {32'd0, a};
        mul_b = {32'd0, b};
        if (op == ALU_MULH || op == ALU_MULHSU) begin
            mul_a = {{32{a[31]}}, a};
        end
        if (op == ALU_MULH) begin
            mul_b = {{32{b[31]}}, b};
        end
        mul_p = mul_a * mul_b;
    end
`endif

    // Operation select; unknown or disabled operations produce zero.
    always_comb begin
        result = '0;
        case (op)
            ALU_ADD:    result = a + b;
            ALU_SUB:    result = a - b;
            ALU_SLL:    result = a << shamt;
            ALU_SLT:    result = {31'd0, ($signed(a) < $signed(b))};
            ALU_SLTU:   result = {31'd0, (a < b)};
            ALU_XOR:    result = a ^ b;
            ALU_SRL:    result = a >> shamt;
            ALU_SRA:    result = $unsigned($signed(a) >>> shamt);
            ALU_OR:     result = a | b;
            ALU_AND:    result = a & b;
`ifdef EX_ALU_MUL_EN
            ALU_MUL:    result = mul_p[31:0];
            ALU_MULH:   result = mul_p[63:32];
            ALU_MULHSU: result = mul_p[63:32];
            ALU_MULHU:  result = mul_p[63:32];
`endif
            default:    result = '0;
        endcase
    end

endmodule

// File: rtl/ex_alu_unit.sv
// RV32I execute stage: registered OP-IMM, OP and AUIPC results plus decode errors.
// Latency: 1 cycle from operands to outputs; all three paths compute every cycle.
// Backpressure: en=0 holds every output register; rst (sync) clears and overrides en.
// Optional RV32M multiplies on the OP path are enabled by defining EX_ALU_MUL_EN.
module ex_alu_unit
    import ex_alu_pkg::*;
#(
    parameter int XLEN_P = XLEN
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic [2:0]  subfunction_3,
    input  logic [6:0]  subfunction_7,
    input  logic [31:0] input_register1_value,
    input  logic [31:0] input_register2_value,
    input  logic [31:0] immediate,
    input  logic [31:0] program_counter,
    output logic [31:0] itype_result,
    output logic [31:0] rtype_result,
    output logic [31:0] auipc_result,
    output logic        itype_decoding_error,
    output logic        rtype_decoding_error
);

    if (XLEN_P != 32) begin : g_xlen_check
        $error("ex_alu_unit supports only XLEN = 32");
    end

    // Decoded operations and legality for each ALU path
    alu_op_e     r_op;
    alu_op_e     i_op;
    logic        r_illegal;
    logic        i_illegal;
    logic [6:0]  imm_f7;
    logic [31:0] r_alu;
    logic [31:0] i_alu;

    // Register state
    logic [31:0] itype_result_d, itype_result_q;
    logic [31:0] rtype_result_d, rtype_result_q;
    logic [31:0] auipc_result_d, auipc_result_q;
    logic        itype_error_d,  itype_error_q;
    logic        rtype_error_d,  rtype_error_q;

    // The shift-type selector for immediates lives in imm[11:5], like funct7.
    assign imm_f7 = immediate[11:5];

    // OP decode: funct7 picks the variant; anything not listed is illegal.
    always_comb begin
        r_op      = ALU_ADD;
        r_illegal = 1'b0;
        if (subfunction_7 == F7_MULDIV) begin
`ifdef EX_ALU_MUL_EN
            case (subfunction_3)
                F3_ADD:  r_op = ALU_MUL;
                F3_SLL:  r_op = ALU_MULH;
                F3_SLT:  r_op = ALU_MULHSU;
                F3_SLTU: r_op = ALU_MULHU;
                default: r_illegal = 1'b1;   // funct3 1xx (divide) decodes as illegal
            endcase
`else
            r_illegal = 1'b1;
`endif
        end else begin
            case (subfunction_3)
                F3_ADD: begin
                    if (subfunction_7 == F7_BASE) begin
                        r_op = ALU_ADD;
                    end else if (subfunction_7 == F7_ALT) begin
                        r_op = ALU_SUB;
                    end else begin
                        r_illegal = 1'b1;
                    end
                end
                F3_SR: begin
                    if (subfunction_7 == F7_BASE) begin
                        r_op = ALU_SRL;
                    end else if (subfunction_7 == F7_ALT) begin
                        r_op = ALU_SRA;
                    end else begin
                        r_illegal = 1'b1;
                    end
                end
                default: begin
                    r_op      = base_op(subfunction_3);
                    r_illegal = (subfunction_7 != F7_BASE);
                end
            endcase
        end
    end

    // OP-IMM decode: only the shifts constrain imm[11:5]; there is no SUBI.
    always_comb begin
        i_op      = base_op(subfunction_3);
        i_illegal = 1'b0;
        case (subfunction_3)
            F3_SLL: begin
                i_illegal = (imm_f7 != F7_BASE);
            end
            F3_SR: begin
                if (imm_f7 == F7_ALT) begin
                    i_op = ALU_SRA;
                end else if (imm_f7 != F7_BASE) begin
                    i_illegal = 1'b1;
                end
            end
            default: begin
                i_illegal = 1'b0;
            end
        endcase
    end

    ex_alu_core u_r_alu (
        .op     (r_op),
        .a      (input_register1_value),
        .b      (input_register2_value),
        .result (r_alu)
    );

    ex_alu_core u_i_alu (
        .op     (i_op),
        .a      (input_register1_value),
        .b      (immediate),
        .result (i_alu)
    );

    // Next-state: capture new results when enabled, otherwise hold.
    always_comb begin
        itype_result_d = itype_result_q;
        rtype_result_d = rtype_result_q;
        auipc_result_d = auipc_result_q;
        itype_error_d  = itype_error_q;
        rtype_error_d  = rtype_error_q;
        if (en) begin
            itype_result_d = i_illegal ? 32'd0 : i_alu;
            rtype_result_d = r_illegal ? 32'd0 : r_alu;
            auipc_result_d = program_counter + immediate;
            itype_error_d  = i_illegal;
            rtype_error_d  = r_illegal;
        end
    end

    // Output registers; reset wins over en, including during a stall.
    always_ff @(posedge clk) begin
        if (rst) begin
            itype_result_q <= '0;
            rtype_result_q <= '0;
            auipc_result_q <= '0;
            itype_error_q  <= 1'b0;
            rtype_error_q  <= 1'b0;
        end else begin
            itype_result_q <= itype_result_d;
            rtype_result_q <= rtype_result_d;
            auipc_result_q <= auipc_result_d;
            itype_error_q  <= itype_error_d;
            rtype_error_q  <= rtype_error_d;
        end
    end

    assign itype_result         = itype_result_q;
    assign rtype_result         = rtype_result_q;
    assign auipc_result         = auipc_result_q;
    assign itype_decoding_error = itype_error_q;
    assign rtype_decoding_error = rtype_error_q;

endmodule

// File: tb/tb_ex_alu_unit.sv
// Self-checking bench for ex_alu_unit: directed cases plus randomized traffic
// checked against a behavioural model of the RV32I (and optional RV32M) rules.
module tb_ex_alu_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [31:0] rs1;
    logic [31:0] rs2;
    logic [31:0] imm;
    logic [31:0] pc;
    logic [31:0] itype_result;
    logic [31:0] rtype_result;
    logic [31:0] auipc_result;
    logic        itype_err;
    logic        rtype_err;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    ex_alu_unit dut (
        .clk                   (clk),
        .rst                   (rst),
        .en                    (en),
        .subfunction_3         (f3),
        .subfunction_7         (f7),
        .input_register1_value (rs1),
        .input_register2_value (rs2),
        .immediate             (imm),
        .program_counter       (pc),
        .itype_result          (itype_result),
        .rtype_result          (rtype_result),
        .auipc_result          (auipc_result),
        .itype_decoding_error  (itype_err),
        .rtype_decoding_error  (rtype_err)
    );

    // ---------------- reference model ----------------
    function automatic logic [31:0] m_sra(input logic [31:0] a, input int sh);
        if (a[31]) return ~((~a) >> sh);
        return a >> sh;
    endfunction

    function automatic logic [31:0] m_slt(input logic [31:0] a, input logic [31:0] b);
        int sa = a;
        int sb = b;
        return (sa < sb) ? 32'd1 : 32'd0;
    endfunction

    // returns {error, result}
    function automatic logic [32:0] model_r(input logic [2:0] fn3, input logic [6:0] fn7,
                                            input logic [31:0] a, input logic [31:0] b);
        int              sh = int'(b[4:0]);
        int              ia = a;
        int              ib = b;
        longint          la = ia;
        longint          lb = ib;
        longint          zb = {32'd0, b};
        longint unsigned ua = {32'd0, a};
        longint unsigned ub = {32'd0, b};
        longint          sp;
        longint unsigned up;
        if (fn7 == 7'h01) begin
`ifdef EX_ALU_MUL_EN
            case (fn3)
                3'd0: begin up = ua * ub; return {1'b0, up[31:0]}; end
                3'd1: begin sp = la * lb; return {1'b0, sp[63:32]}; end
                3'd2: begin sp = la * zb; return {1'b0, sp[63:32]}; end
                3'd3: begin up = ua * ub; return {1'b0, up[63:32]}; end
                default: return {1'b1, 32'd0};
            endcase
`else
            return {1'b1, 32'd0};
`endif
        end
        if (fn3 == 3'd0) begin
            if (fn7 == 7'h00) return {1'b0, a + b};
            if (fn7 == 7'h20) return {1'b0, a - b};
            return {1'b1, 32'd0};
        end
        if (fn3 == 3'd5) begin
            if (fn7 == 7'h00) return {1'b0, a >> sh};
            if (fn7 == 7'h20) return {1'b0, m_sra(a, sh)};
            return {1'b1, 32'd0};
        end
        if (fn7 != 7'h00) return {1'b1, 32'd0};
        case (fn3)
            3'd1:    return {1'b0, a << sh};
            3'd2:    return {1'b0, m_slt(a, b)};
            3'd3:    return {1'b0, (a < b) ? 32'd1 : 32'd0};
            3'd4:    return {1'b0, a ^ b};
            3'd6:    return {1'b0, a | b};
            default: return {1'b0, a & b};
        endcase
    endfunction

    function automatic logic [32:0] model_i(input logic [2:0] fn3,
                                            input logic [31:0] a, input logic [31:0] im);
        logic [6:0] top = im[11:5];
        int         sh  = int'(im[4:0]);
        case (fn3)
            3'd0: return {1'b0, a + im};
            3'd1: return (top == 7'h00) ? {1'b0, a << sh} : {1'b1, 32'd0};
            3'd2: return {1'b0, m_slt(a, im)};
            3'd3: return {1'b0, (a < im) ? 32'd1 : 32'd0};
            3'd4: return {1'b0, a ^ im};
            3'd5: begin
                if (top == 7'h00) return {1'b0, a >> sh};
                if (top == 7'h20) return {1'b0, m_sra(a, sh)};
                return {1'b1, 32'd0};
            end
            3'd6: return {1'b0, a | im};
            default: return {1'b0, a & im};
        endcase
    endfunction

    // ---------------- stimulus ----------------
    // Drive one cycle of inputs at the falling edge, sample 1ns after the rising edge.
    task automatic step(input logic r, input logic e, input logic [2:0] fn3, input logic [6:0] fn7,
                        input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] im, input logic [31:0] p);
        @(negedge clk);
        rst = r; en = e; f3 = fn3; f7 = fn7; rs1 = a; rs2 = b; imm = im; pc = p;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        step(1'b1, 1'b1, 3'd0, 7'd0, 32'h1234_5678, 32'h1, 32'h55, 32'h100);
        n_checks++;
        if ({itype_result, rtype_result, auipc_result, itype_err, rtype_err} !== 98'd0) begin
            n_fail++;
            $display("FAIL reset: i=%h r=%h a=%h ie=%b re=%b, want all zero",
                     itype_result, rtype_result, auipc_result, itype_err, rtype_err);
        end
        for (int k = 0; k < 3; k++) begin
            step(1'b0, 1'b0, 3'd0, 7'd0, 32'h1, 32'h2, 32'h3, 32'h4);
            n_checks++;
            if ({itype_result, rtype_result, auipc_result, itype_err, rtype_err} !== 98'd0) begin
                n_fail++;
                $display("FAIL reset_hold[%0d]: i=%h r=%h a=%h, want all zero", k,
                         itype_result, rtype_result, auipc_result);
            end
        end
    endtask

    task automatic test_latency;
        step(1'b0, 1'b1, 3'd0, 7'h00, 32'h10, 32'h20, 32'h0, 32'h0);
        @(negedge clk);
        f7 = 7'h20;
        #1;
        n_checks++;
        if (rtype_result !== 32'h30) begin
            n_fail++;
            $display("FAIL latency_pre_edge: got %h want 00000030", rtype_result);
        end
        @(posedge clk);
        #1;
        n_checks++;
        if (rtype_result !== 32'hFFFF_FFF0) begin
            n_fail++;
            $display("FAIL latency_post_edge: got %h want fffffff0", rtype_result);
        end
    endtask

    task automatic test_rtype;
        logic [2:0]  t3 [8] = '{3'd0, 3'd0, 3'd2, 3'd3, 3'd4, 3'd6, 3'd7, 3'd1};
        logic [6:0]  t7 [8] = '{7'h00, 7'h20, 7'h00, 7'h00, 7'h00, 7'h00, 7'h00, 7'h00};
        logic [31:0] te [8] = '{32'h4, 32'h6, 32'h0, 32'h1, 32'hFFFF_FFFA,
                                32'hFFFF_FFFF, 32'h5, 32'h8000_0000};
        for (int k = 0; k < 8; k++) begin
            step(1'b0, 1'b1, t3[k], t7[k], 32'h5, 32'hFFFF_FFFF, 32'h0, 32'h0);
            n_checks++;
            if (rtype_result !== te[k] || rtype_err !== 1'b0) begin
                n_fail++;
                $display("FAIL rtype[%0d] f3=%0d f7=%h: got %h err=%b want %h err=0",
                         k, t3[k], t7[k], rtype_result, rtype_err, te[k]);
            end
        end
    endtask

    task automatic test_shifts;
        // R-type shifts: rs1=0x80000000 by 4, by 31 (SRA), by 0
        logic [6:0]  r7 [4] = '{7'h00, 7'h20, 7'h20, 7'h20};
        logic [31:0] rb [4] = '{32'd4, 32'd4, 32'd31, 32'd0};
        logic [31:0] re [4] = '{32'h0800_0000, 32'hF800_0000, 32'hFFFF_FFFF, 32'h8000_0000};
        // I-type shifts
        logic [2:0]  i3 [4] = '{3'd1, 3'd5, 3'd1, 3'd5};
        logic [31:0] ia [4] = '{32'h1, 32'h8000_0000, 32'h8000_0000, 32'h8000_0000};
        logic [31:0] ii [4] = '{32'h1F, 32'h404, 32'h404, 32'hC04};
        logic [31:0] ie [4] = '{32'h8000_0000, 32'hF800_0000, 32'h0, 32'h0};
        logic        ib [4] = '{1'b0, 1'b0, 1'b1, 1'b1};
        for (int k = 0; k < 4; k++) begin
            step(1'b0, 1'b1, 3'd5, r7[k], 32'h8000_0000, rb[k], 32'h0, 32'h0);
            n_checks++;
            if (rtype_result !== re[k] || rtype_err !== 1'b0) begin
                n_fail++;
                $display("FAIL rshift[%0d]: got %h err=%b want %h err=0", k, rtype_result, rtype_err, re[k]);
            end
        end
        for (int k = 0; k < 4; k++) begin
            step(1'b0, 1'b1, i3[k], 7'h00, ia[k], 32'h0, ii[k], 32'h0);
            n_checks++;
            if (itype_result !== ie[k] || itype_err !== ib[k]) begin
                n_fail++;
                $display("FAIL ishift[%0d]: got %h err=%b want %h err=%b",
                         k, itype_result, itype_err, ie[k], ib[k]);
            end
        end
    endtask

    task automatic test_itype;
        logic [2:0]  t3 [5] = '{3'd0, 3'd3, 3'd7, 3'd4, 3'd2};
        logic [31:0] te [5] = '{32'h2, 32'h1, 32'h3, 32'hFFFF_FFFC, 32'h0};
        for (int k = 0; k < 5; k++) begin
            step(1'b0, 1'b1, t3[k], 7'h00, 32'h3, 32'h0, 32'hFFFF_FFFF, 32'h0);
            n_checks++;
            if (itype_result !== te[k] || itype_err !== 1'b0) begin
                n_fail++;
                $display("FAIL itype[%0d] f3=%0d: got %h err=%b want %h err=0",
                         k, t3[k], itype_result, itype_err, te[k]);
            end
        end
    endtask

    task automatic test_auipc;
        step(1'b0, 1'b1, 3'd0, 7'h00, 32'h0, 32'h0, 32'h1234_5000, 32'h0000_0100);
        n_checks++;
        if (auipc_result !== 32'h1234_5100) begin
            n_fail++;
            $display("FAIL auipc: got %h want 12345100", auipc_result);
        end
        step(1'b0, 1'b1, 3'd0, 7'h00, 32'h0, 32'h0, 32'h0000_2000, 32'hFFFF_F000);
        n_checks++;
        if (auipc_result !== 32'h0000_1000) begin
            n_fail++;
            $display("FAIL auipc_wrap: got %h want 00001000", auipc_result);
        end
    endtask

    task automatic test_muldiv;
`ifdef EX_ALU_MUL_EN
        logic [2:0]  t3 [4] = '{3'd0, 3'd3, 3'd1, 3'd4};
        logic [31:0] te [4] = '{32'hFFFF_FFFE, 32'h1, 32'hFFFF_FFFF, 32'h0};
        logic        tb [4] = '{1'b0, 1'b0, 1'b0, 1'b1};
`else
        logic [2:0]  t3 [4] = '{3'd0, 3'd3, 3'd1, 3'd4};
        logic [31:0] te [4] = '{32'h0, 32'h0, 32'h0, 32'h0};
        logic        tb [4] = '{1'b1, 1'b1, 1'b1, 1'b1};
`endif
        for (int k = 0; k < 4; k++) begin
            step(1'b0, 1'b1, t3[k], 7'h01, 32'hFFFF_FFFF, 32'h2, 32'h0, 32'h0);
            n_checks++;
            if (rtype_result !== te[k] || rtype_err !== tb[k]) begin
                n_fail++;
                $display("FAIL muldiv[%0d] f3=%0d: got %h err=%b want %h err=%b",
                         k, t3[k], rtype_result, rtype_err, te[k], tb[k]);
            end
        end
        // a funct7 that is neither base, alt nor muldiv
        step(1'b0, 1'b1, 3'd4, 7'h20, 32'h5, 32'h5, 32'h0, 32'h0);
        n_checks++;
        if (rtype_result !== 32'h0 || rtype_err !== 1'b1) begin
            n_fail++;
            $display("FAIL illegal_xor_f7: got %h err=%b want 00000000 err=1", rtype_result, rtype_err);
        end
    endtask

    task automatic test_stall_reset;
        step(1'b0, 1'b1, 3'd0, 7'h00, 32'h5, 32'hFFFF_FFFF, 32'h7, 32'h100);
        for (int k = 0; k < 3; k++) begin
            step(1'b0, 1'b0, 3'd1, 7'h7F, $urandom, $urandom, $urandom, $urandom);
            n_checks++;
            if (rtype_result !== 32'h4 || itype_result !== 32'hC || auipc_result !== 32'h107 ||
                rtype_err !== 1'b0 || itype_err !== 1'b0) begin
                n_fail++;
                $display("FAIL stall_hold[%0d]: r=%h i=%h a=%h want 00000004 0000000c 00000107",
                         k, rtype_result, itype_result, auipc_result);
            end
        end
        step(1'b1, 1'b0, 3'd0, 7'h00, 32'h5, 32'h5, 32'h5, 32'h5);
        n_checks++;
        if ({itype_result, rtype_result, auipc_result, itype_err, rtype_err} !== 98'd0) begin
            n_fail++;
            $display("FAIL reset_in_stall: r=%h i=%h a=%h want all zero",
                     rtype_result, itype_result, auipc_result);
        end
    endtask

    task automatic test_random;
        logic [31:0] exp_i = 32'd0, exp_r = 32'd0, exp_a = 32'd0;
        logic        exp_ie = 1'b0, exp_re = 1'b0;
        logic [6:0]  sel7 [4] = '{7'h00, 7'h20, 7'h01, 7'h00};
        logic [32:0] mr, mi;
        logic [2:0]  c3;
        logic [6:0]  c7;
        logic [11:0] low;
        logic [31:0] a, b, im, p;
        logic        r, e;
        for (int k = 0; k < 400; k++) begin
            c3  = 3'($urandom_range(0, 7));
            c7  = sel7[$urandom_range(0, 3)];
            if ($urandom_range(0, 9) == 0) c7 = 7'($urandom);
            low = 12'($urandom);
            low[11:5] = sel7[$urandom_range(0, 3)];
            if ($urandom_range(0, 7) == 0) low[11:5] = 7'($urandom);
            im  = {{20{low[11]}}, low};
            if ($urandom_range(0, 3) == 0) im = {20'($urandom), 12'd0};
            a   = $urandom;
            b   = $urandom;
            p   = $urandom;
            r   = ($urandom_range(0, 31) == 0);
            e   = ($urandom_range(0, 3) != 0);
            step(r, e, c3, c7, a, b, im, p);
            mr = model_r(c3, c7, a, b);
            mi = model_i(c3, a, im);
            if (r) begin
                exp_i = 32'd0; exp_r = 32'd0; exp_a = 32'd0; exp_ie = 1'b0; exp_re = 1'b0;
            end else if (e) begin
                exp_i = mi[31:0]; exp_ie = mi[32];
                exp_r = mr[31:0]; exp_re = mr[32];
                exp_a = p + im;
            end
            n_checks++;
            if (itype_result !== exp_i || itype_err !== exp_ie || rtype_result !== exp_r ||
                rtype_err !== exp_re || auipc_result !== exp_a) begin
                n_fail++;
                $display("FAIL random[%0d] f3=%0d f7=%h a=%h b=%h imm=%h: i=%h/%b r=%h/%b au=%h want i=%h/%b r=%h/%b au=%h",
                         k, c3, c7, a, b, im, itype_result, itype_err, rtype_result, rtype_err,
                         auipc_result, exp_i, exp_ie, exp_r, exp_re, exp_a);
            end
        end
    endtask

    initial begin
        rst = 1'b0; en = 1'b0; f3 = '0; f7 = '0; rs1 = '0; rs2 = '0; imm = '0; pc = '0;
        test_reset();
        test_latency();
        test_rtype();
        test_shifts();
        test_itype();
        test_auipc();
        test_muldiv();
        test_stall_reset();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
